sdram_arbit: RTL and testbench
==============================

// Module: sdram_arbit
// PURPOSE
//  Central SDRAM command arbiter: the granting end of the req/en/end handshake
//  used by the init, auto-refresh, write and read engines. Holds the engine FSM,
//  issues one-cycle grant pulses (ref_en/wr_en/rd_en), and muxes the granted
//  engine's cmd/addr/bank/dq onto the SDRAM pins. Sits between the engines and the top-level pads.
// PARAMETERS
//  ADDR_W   13   SDRAM row/col address width
//  BANK_W   2    bank address width
//  DATA_W   16   SDRAM data width
// PORTS
//  sclk          in   1        system clock, all logic on rising edge
//  s_rst         in   1        asynchronous reset, active-high
//  init_cmd      in   4        {cs_n,ras_n,cas_n,we_n} from init engine
//  init_addr     in   ADDR_W   address from init engine
//  flag_init_end in   1        init complete (level, stays high)
//  ref_req       in   1        refresh request (level, held until ref_en seen)
//  flag_ref_end  in   1        refresh sequence done (1-cycle pulse)
//  aref_cmd      in   4        command from refresh engine
//  aref_addr     in   ADDR_W   address from refresh engine (A10=1)
//  ref_en        out  1        refresh grant pulse
//  wr_req        in   1        write request (level)
//  flag_wr_end   in   1        write burst done (1-cycle pulse)
//  wr_cmd        in   4        command from write engine
//  wr_addr       in   ADDR_W   address from write engine
//  wr_bank       in   BANK_W   bank from write engine
//  wr_data       in   DATA_W   write data
//  wr_data_oe    in   1        write engine drives dq this cycle
//  wr_en         out  1        write grant pulse
//  rd_req        in   1        read request (level)
//  flag_rd_end   in   1        read burst done (1-cycle pulse)
//  rd_cmd        in   4        command from read engine
//  rd_addr       in   ADDR_W   address from read engine
//  rd_bank       in   BANK_W   bank from read engine
//  rd_en         out  1        read grant pulse
//  sdram_cke     out  1        clock enable
//  sdram_cmd     out  4        {cs_n,ras_n,cas_n,we_n} to pads
//  sdram_addr    out  ADDR_W   address to pads
//  sdram_bank    out  BANK_W   bank to pads
//  sdram_dq_out  out  DATA_W   dq output data
//  sdram_dq_oe   out  1        dq tristate enable (1 = drive)
// BEHAVIOUR
//  - Reset: state=INIT, ref_en/wr_en/rd_en=0, last_wr=0, sdram_cke=1
//    (constant 1 thereafter); mux outputs follow INIT rules below.
//  - States INIT, ARBIT, AREF, WRITE, READ (one-hot or binary, registered).
//    INIT->ARBIT on flag_init_end=1. ARBIT: priority ref_req > (wr/rd).
//    wr_req&rd_req both high: grant the one not granted last (last_wr toggles);
//    single requester granted directly. AREF->ARBIT on flag_ref_end,
//    WRITE->ARBIT on flag_wr_end, READ->ARBIT on flag_rd_end.
//  - Grant: *_en registered; high exactly one cycle = first cycle of the new
//    state (same edge as transition). Never asserted outside that cycle.
//  - Requests ignored outside ARBIT; no preemption (write/read engines watch
//    ref_req themselves and terminate bursts early).
//  - End pulse with new request pending: return to ARBIT, grant on next edge
//    -> minimum one ARBIT cycle (NOP) between engines.
//  - End flag of a non-active engine is ignored. End flag in ARBIT ignored.
//  - Pin mux, combinational from state (zero added latency):
//    INIT: init_cmd/init_addr, bank 0; AREF: aref_cmd/aref_addr, bank 0;
//    WRITE: wr_cmd/wr_addr/wr_bank; READ: rd_cmd/rd_addr/rd_bank;
//    ARBIT: CMD_NOP 4'b0111, addr 0, bank 0.
//  - sdram_dq_out=wr_data always; sdram_dq_oe=(state==WRITE)&wr_data_oe.
//  - Reset mid-burst: immediately INIT, grants cleared, dq_oe=0; after reset
//    waits for flag_init_end again.
// STRUCTURE
//  - Shared package: CMD_NOP 4'b0111, CMD_PRE 4'b0010, CMD_AREF 4'b0001,
//    state encoding constants (shared with top-level debug).
//  - Single module; no sub-module (FSM + mux is flat).
// TESTING
//  - Reset held, init_cmd=4'b0010 -> sdram_cmd=4'b0010, all en=0, cke=1;
//    flag_init_end=1 -> next cycle ARBIT, sdram_cmd=4'b0111.
//  - ARBIT, ref_req=wr_req=rd_req=1 same cycle -> ref_en 1 cycle, AREF;
//    sdram_cmd tracks aref_cmd, sdram_addr=13'h0400 during AREF CMD.
//  - wr_req&rd_req held, alternate ends -> grants wr,rd,wr,rd (last_wr toggle).
//  - flag_wr_end with ref_req already high -> 1 ARBIT NOP cycle, then ref_en.
//  - WRITE, wr_data_oe=1, wr_data=16'hA5A5 -> dq_oe=1, dq_out=16'hA5A5;
//    in READ wr_data_oe=1 -> dq_oe=0.
//  - s_rst pulsed mid-WRITE -> INIT, dq_oe=0, en=0; flag_rd_end while in
//    WRITE -> no state change.

Source files
------------

// File: rtl/sdram_arbit_pkg.sv
// Shared SDRAM command encodings and arbiter state constants.
// State constants are also used by top-level debug logic.
package sdram_arbit_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_ARBIT = 3'd1;
    localparam logic [2:0] ST_AREF  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;

endpackage

// File: rtl/sdram_arbit.sv
// Central SDRAM arbiter: grants init/refresh/write/read engines in turn
// and muxes the active engine onto the SDRAM pins.
module sdram_arbit
    import sdram_arbit_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int BANK_W = 2,
    parameter int DATA_W = 16
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              flag_init_end,
    input  logic              ref_req,
    input  logic              flag_ref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    output logic              ref_en,
    input  logic              wr_req,
    input  logic              flag_wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_data_oe,
    output logic              wr_en,
    input  logic              rd_req,
    input  logic              flag_rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BANK_W-1:0] rd_bank,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              sdram_dq_oe
);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       r_last_wr;
    logic       r_ref_en;
    logic       r_wr_en;
    logic       r_rd_en;

    // Refresh always wins; a write/read tie goes to whichever was not granted last.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:  if (flag_init_end) w_next = ST_ARBIT;
            ST_ARBIT: begin
                if (ref_req)
                    w_next = ST_AREF;
                else if (wr_req && rd_req)
                    w_next = r_last_wr ? ST_READ : ST_WRITE;
                else if (wr_req)
                    w_next = ST_WRITE;
                else if (rd_req)
                    w_next = ST_READ;
            end
            ST_AREF:  if (flag_ref_end) w_next = ST_ARBIT;
            ST_WRITE: if (flag_wr_end)  w_next = ST_ARBIT;
            ST_READ:  if (flag_rd_end)  w_next = ST_ARBIT;
            default:  w_next = ST_INIT;
        endcase
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            r_state   <= ST_INIT;
            r_last_wr <= 1'b0;
            r_ref_en  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_ref_en <= (r_state == ST_ARBIT) && (w_next == ST_AREF);
            r_wr_en  <= (r_state == ST_ARBIT) && (w_next == ST_WRITE);
            r_rd_en  <= (r_state == ST_ARBIT) && (w_next == ST_READ);
            if (r_state == ST_ARBIT && w_next == ST_WRITE)
                r_last_wr <= 1'b1;
            else if (r_state == ST_ARBIT && w_next == ST_READ)
                r_last_wr <= 1'b0;
        end
    end

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        case (r_state)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: ;
        endcase
    end

    assign ref_en       = r_ref_en;
    assign wr_en        = r_wr_en;
    assign rd_en        = r_rd_en;
    assign sdram_cke    = 1'b1;
    assign sdram_dq_out = wr_data;
    assign sdram_dq_oe  = (r_state == ST_WRITE) && wr_data_oe;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: walks init, refresh, write/read alternation,
// dq enable and async reset, checking pins and grant pulses each step.
module tb_sdram_arbit;

    logic        sclk = 1'b0;
    logic        s_rst;
    logic [3:0]  init_cmd;
    logic [12:0] init_addr;
    logic        flag_init_end;
    logic        ref_req;
    logic        flag_ref_end;
    logic [3:0]  aref_cmd;
    logic [12:0] aref_addr;
    logic        ref_en;
    logic        wr_req;
    logic        flag_wr_end;
    logic [3:0]  wr_cmd;
    logic [12:0] wr_addr;
    logic [1:0]  wr_bank;
    logic [15:0] wr_data;
    logic        wr_data_oe;
    logic        wr_en;
    logic        rd_req;
    logic        flag_rd_end;
    logic [3:0]  rd_cmd;
    logic [12:0] rd_addr;
    logic [1:0]  rd_bank;
    logic        rd_en;
    logic        sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_bank;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;

    int total = 0;
    int bad   = 0;

    sdram_arbit #(.ADDR_W(13), .BANK_W(2), .DATA_W(16)) dut (
        .sclk(sclk), .s_rst(s_rst),
        .init_cmd(init_cmd), .init_addr(init_addr), .flag_init_end(flag_init_end),
        .ref_req(ref_req), .flag_ref_end(flag_ref_end), .aref_cmd(aref_cmd),
        .aref_addr(aref_addr), .ref_en(ref_en),
        .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
        .wr_bank(wr_bank), .wr_data(wr_data), .wr_data_oe(wr_data_oe), .wr_en(wr_en),
        .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
        .rd_bank(rd_bank), .rd_en(rd_en),
        .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
        .sdram_bank(sdram_bank), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    // grants packed {ref,wr,rd}
    task automatic chk_pins(input string tag, input logic [3:0] cmd, input logic [12:0] addr,
                            input logic [1:0] bank, input logic [2:0] en);
        chk({tag, ".cmd"},  sdram_cmd,  cmd);
        chk({tag, ".addr"}, sdram_addr, addr);
        chk({tag, ".bank"}, sdram_bank, bank);
        chk({tag, ".en"},   {ref_en, wr_en, rd_en}, en);
    endtask

    initial begin
        s_rst = 1'b1;
        init_cmd = 4'b0010; init_addr = 13'h0123; flag_init_end = 1'b0;
        ref_req = 1'b0; flag_ref_end = 1'b0; aref_cmd = 4'b0001; aref_addr = 13'h0400;
        wr_req = 1'b0; flag_wr_end = 1'b0; wr_cmd = 4'b0100; wr_addr = 13'h00AA;
        wr_bank = 2'd2; wr_data = 16'hA5A5; wr_data_oe = 1'b0;
        rd_req = 1'b0; flag_rd_end = 1'b0; rd_cmd = 4'b0101; rd_addr = 13'h0155;
        rd_bank = 2'd1;

        tick(); tick();
        chk_pins("rst", 4'b0010, 13'h0123, 2'd0, 3'b000);
        chk("rst.cke", sdram_cke, 1'b1);
        chk("rst.oe", sdram_dq_oe, 1'b0);
        s_rst = 1'b0;
        tick();
        chk_pins("init_wait", 4'b0010, 13'h0123, 2'd0, 3'b000);

        flag_init_end = 1'b1;
        tick();
        chk_pins("arbit", 4'b0111, 13'h0000, 2'd0, 3'b000);

        // all three request together: refresh wins
        ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        tick();
        chk_pins("aref", 4'b0001, 13'h0400, 2'd0, 3'b100);
        ref_req = 1'b0;
        tick();
        chk_pins("aref2", 4'b0001, 13'h0400, 2'd0, 3'b000);
        flag_ref_end = 1'b1;
        tick();
        flag_ref_end = 1'b0;
        chk_pins("arbit2", 4'b0111, 13'h0000, 2'd0, 3'b000);

        tick();
        chk_pins("wr1", 4'b0100, 13'h00AA, 2'd2, 3'b010);
        wr_data_oe = 1'b1;
        #1;
        chk("wr1.oe", sdram_dq_oe, 1'b1);
        chk("wr1.dq", sdram_dq_out, 16'hA5A5);
        flag_rd_end = 1'b1;
        tick();
        flag_rd_end = 1'b0;
        chk_pins("wr1_rdend", 4'b0100, 13'h00AA, 2'd2, 3'b000);
        flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        chk_pins("arbit3", 4'b0111, 13'h0000, 2'd0, 3'b000);
        chk("arbit3.oe", sdram_dq_oe, 1'b0);

        tick();
        chk_pins("rd1", 4'b0101, 13'h0155, 2'd1, 3'b001);
        chk("rd1.oe", sdram_dq_oe, 1'b0);
        flag_rd_end = 1'b1;
        tick();
        flag_rd_end = 1'b0;
        chk_pins("arbit4", 4'b0111, 13'h0000, 2'd0, 3'b000);
        tick();
        chk_pins("wr2", 4'b0100, 13'h00AA, 2'd2, 3'b010);

        // refresh pending when the write ends: one NOP cycle then ref grant
        ref_req = 1'b1; flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        chk_pins("arbit5", 4'b0111, 13'h0000, 2'd0, 3'b000);
        tick();
        ref_req = 1'b0;
        chk_pins("aref3", 4'b0001, 13'h0400, 2'd0, 3'b100);
        flag_ref_end = 1'b1;
        tick();
        flag_ref_end = 1'b0;
        chk_pins("arbit6", 4'b0111, 13'h0000, 2'd0, 3'b000);
        tick();
        chk_pins("rd2", 4'b0101, 13'h0155, 2'd1, 3'b001);
        flag_rd_end = 1'b1;
        tick();
        flag_rd_end = 1'b0;
        tick();
        chk_pins("wr3", 4'b0100, 13'h00AA, 2'd2, 3'b010);

        // async reset mid-write
        wr_req = 1'b0; rd_req = 1'b0; flag_init_end = 1'b0;
        chk("wr3.oe", sdram_dq_oe, 1'b1);
        s_rst = 1'b1;
        #1;
        chk_pins("rst_mid", 4'b0010, 13'h0123, 2'd0, 3'b000);
        chk("rst_mid.oe", sdram_dq_oe, 1'b0);
        #2;
        s_rst = 1'b0;
        tick();
        chk_pins("reinit", 4'b0010, 13'h0123, 2'd0, 3'b000);
        flag_init_end = 1'b1;
        tick();
        chk_pins("arbit7", 4'b0111, 13'h0000, 2'd0, 3'b000);

        // end flag in ARBIT with no requests is ignored
        flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        chk_pins("arbit_idle", 4'b0111, 13'h0000, 2'd0, 3'b000);

        // single reader after reset: last_wr cleared, read granted directly
        rd_req = 1'b1;
        tick();
        chk_pins("rd3", 4'b0101, 13'h0155, 2'd1, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
